// File: rtl/fsmc_cfg_write_slave_pkg.sv
// Register map, CTRL bit positions and reset defaults for the FSMC config write slave.
package fsmc_cfg_write_slave_pkg;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_DELAY_LO = 3'd1;
  localparam logic [2:0] A_DELAY_HI = 3'd2;
  localparam logic [2:0] A_WIDTH    = 3'd3;
  localparam logic [2:0] A_GAP      = 3'd4;
  localparam logic [2:0] A_CDELAY   = 3'd5;
  localparam logic [2:0] A_SCOUNT   = 3'd6;
  localparam logic [2:0] A_SCRATCH  = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 7;

  localparam int SAMPLE_MAX_DEF = 10000;

  typedef struct packed {
    logic [23:0] pulse_delay;
    logic [7:0]  pulse_width;
    logic [7:0]  pulse_gap;
    logic [15:0] capture_delay;
    logic [15:0] sample_count;
    logic [15:0] scratch;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    pulse_delay:   24'd6400000,
    pulse_width:   8'd10,
    pulse_gap:     8'd13,
    capture_delay: 16'd5000,
    sample_count:  16'd10000,
    scratch:       16'd0
  };

  function automatic logic [15:0] clamp_count(input logic [15:0] v, input logic [15:0] vmax);
    if (v == 16'd0)     return 16'd1;
    else if (v > vmax)  return vmax;
    else                return v;
  endfunction

endpackage

// File: rtl/fsmc_cfg_write_slave_we_sync.sv
// NE/WE synchroniser plus low-phase length filter; emits accept (latch data) and commit pulses.
module fsmc_we_sync #(
  parameter int WE_MIN_CYC = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ne_i,
  input  logic we_i,
  output logic accept_o,
  output logic commit_o
);

  localparam int CW = $clog2(WE_MIN_CYC + 1);

  logic [1:0]    ne_sync_q, we_sync_q;
  logic          we_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          commit_q, commit_d;
  logic          ne_s, we_s, low, rise;

  assign ne_s = ne_sync_q[1];
  assign we_s = we_sync_q[1];
  assign low  = ~we_s & ~ne_s;
  assign rise = we_s & ~we_prev_q;

  always_comb begin
    cnt_d = '0;
    if (low) cnt_d = (cnt_q == CW'(WE_MIN_CYC)) ? cnt_q : cnt_q + CW'(1);
    // Fires once per low phase: the counter saturates after reaching the threshold.
    accept_o = low && (cnt_q == CW'(WE_MIN_CYC - 1));
    commit_d = rise & armed_q;
    armed_d  = armed_q;
    if (accept_o)                    armed_d = 1'b1;
    else if (rise || (ne_s & ~we_s)) armed_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ne_sync_q <= 2'b11;
      we_sync_q <= 2'b11;
      we_prev_q <= 1'b1;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      ne_sync_q <= {ne_sync_q[0], ne_i};
      we_sync_q <= {we_sync_q[0], we_i};
      we_prev_q <= we_s;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      commit_q  <= commit_d;
    end
  end

  assign commit_o = commit_q;

endmodule

// File: rtl/fsmc_cfg_write_slave.sv
// FSMC write-side register file: filtered MCU writes update pulse/capture timing and issue commands.
module fsmc_cfg_write_slave
  import fsmc_cfg_write_slave_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int WE_MIN_CYC = 3,
  parameter int SAMPLE_MAX = SAMPLE_MAX_DEF
) (
  input  logic              clk_80mhz,
  input  logic              rst_n,
  input  logic              FPGA_NE,
  input  logic              FPGA_WE,
  input  logic [ADDR_W-1:0] FSMC_A,
  input  logic [15:0]       FSMC_D_IN,
  input  logic              measurement_active,
  output logic              start_pulse,
  output logic              abort_pulse,
  output logic [23:0]       pulse_delay,
  output logic [7:0]        pulse_width,
  output logic [7:0]        pulse_gap,
  output logic [15:0]       capture_delay,
  output logic [15:0]       sample_count,
  output logic [15:0]       scratch,
  output logic              reg_wr_strobe,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic              reject_flag,
  output logic              bad_addr_flag
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(A_SCRATCH);
  localparam logic [15:0]       SMAX      = 16'(SAMPLE_MAX);

  logic              accept, commit;
  logic [ADDR_W-1:0] a_q, hold_addr_q, wr_addr_q, wr_addr_d;
  logic [15:0]       d_q, hold_data_q, lo_q, lo_d;
  cfg_t              cfg_q, cfg_d;
  logic              start_q, start_d, abort_q, abort_d, strobe_q, strobe_d;
  logic              reject_q, reject_d, bad_q, bad_d;
  logic [2:0]        idx;
  logic              bad_addr, locked;

  fsmc_we_sync #(.WE_MIN_CYC(WE_MIN_CYC)) u_we_sync (
    .clk_i    (clk_80mhz),
    .rst_ni   (rst_n),
    .ne_i     (FPGA_NE),
    .we_i     (FPGA_WE),
    .accept_o (accept),
    .commit_o (commit)
  );

  assign idx      = hold_addr_q[2:0];
  assign bad_addr = hold_addr_q > LAST_ADDR;
  // Timing registers (1..6) must not change under a running shot; CTRL and SCRATCH stay live.
  assign locked   = measurement_active && (idx != A_CTRL) && (idx != A_SCRATCH);

  always_comb begin
    cfg_d     = cfg_q;
    lo_d      = lo_q;
    wr_addr_d = wr_addr_q;
    reject_d  = reject_q;
    bad_d     = bad_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    strobe_d  = 1'b0;
    if (commit) begin
      strobe_d  = 1'b1;
      wr_addr_d = hold_addr_q;
      if (bad_addr) begin
        bad_d = 1'b1;
      end else if (locked) begin
        reject_d = 1'b1;
      end else begin
        case (idx)
          A_CTRL: begin
            abort_d = hold_data_q[CTRL_ABORT];
            start_d = hold_data_q[CTRL_START] & ~hold_data_q[CTRL_ABORT];
            if (hold_data_q[CTRL_CLEAR]) begin
              reject_d = 1'b0;
              bad_d    = 1'b0;
            end
          end
          A_DELAY_LO: lo_d = hold_data_q;
          A_DELAY_HI: cfg_d.pulse_delay = {hold_data_q[7:0], lo_q};
          A_WIDTH:    cfg_d.pulse_width = (hold_data_q[7:0] == 8'd0) ? 8'd1 : hold_data_q[7:0];
          A_GAP:      cfg_d.pulse_gap = hold_data_q[7:0];
          A_CDELAY:   cfg_d.capture_delay = hold_data_q;
          A_SCOUNT:   cfg_d.sample_count = clamp_count(hold_data_q, SMAX);
          default:    cfg_d.scratch = hold_data_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_80mhz or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      d_q         <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      lo_q        <= '0;
      cfg_q       <= CFG_RESET;
      wr_addr_q   <= '0;
      reject_q    <= 1'b0;
      bad_q       <= 1'b0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      a_q <= FSMC_A;
      d_q <= FSMC_D_IN;
      if (accept) begin
        hold_addr_q <= a_q;
        hold_data_q <= d_q;
      end
      lo_q      <= lo_d;
      cfg_q     <= cfg_d;
      wr_addr_q <= wr_addr_d;
      reject_q  <= reject_d;
      bad_q     <= bad_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      strobe_q  <= strobe_d;
    end
  end

  assign start_pulse   = start_q;
  assign abort_pulse   = abort_q;
  assign pulse_delay   = cfg_q.pulse_delay;
  assign pulse_width   = cfg_q.pulse_width;
  assign pulse_gap     = cfg_q.pulse_gap;
  assign capture_delay = cfg_q.capture_delay;
  assign sample_count  = cfg_q.sample_count;
  assign scratch       = cfg_q.scratch;
  assign reg_wr_strobe = strobe_q;
  assign reg_wr_addr   = wr_addr_q;
  assign reject_flag   = reject_q;
  assign bad_addr_flag = bad_q;

endmodule

// File: tb/tb_fsmc_cfg_write_slave.sv
// Directed bench: FSMC write cycles driven on the falling clock edge, outputs sampled 1 ns after rise.
`timescale 1ns/1ps
module tb_fsmc_cfg_write_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ne = 1'b1, we = 1'b1, mact = 1'b0;
  logic [3:0]  a = '0;
  logic [15:0] d = '0;
  logic        start_pulse, abort_pulse, reg_wr_strobe, reject_flag, bad_addr_flag;
  logic [23:0] pulse_delay;
  logic [7:0]  pulse_width, pulse_gap;
  logic [15:0] capture_delay, sample_count, scratch;
  logic [3:0]  reg_wr_addr;

  int checks = 0, fails = 0;
  int stb_n, stb_lat, st_n, ab_n;

  always #6.25 clk = ~clk;

  fsmc_cfg_write_slave dut (
    .clk_80mhz(clk), .rst_n(rst_n), .FPGA_NE(ne), .FPGA_WE(we), .FSMC_A(a), .FSMC_D_IN(d),
    .measurement_active(mact), .start_pulse(start_pulse), .abort_pulse(abort_pulse),
    .pulse_delay(pulse_delay), .pulse_width(pulse_width), .pulse_gap(pulse_gap),
    .capture_delay(capture_delay), .sample_count(sample_count), .scratch(scratch),
    .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr), .reject_flag(reject_flag),
    .bad_addr_flag(bad_addr_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One FSMC write; then watches 8 cycles after WE rise for strobe/start/abort activity.
  task automatic wr(input logic [3:0] addr, input logic [15:0] data, input int low, input bit ne_early);
    @(negedge clk);
    ne = 1'b0; a = addr; d = data; we = 1'b0;
    repeat (low) @(negedge clk);
    if (ne_early) begin
      ne = 1'b1;
      @(negedge clk);
    end
    we = 1'b1; ne = 1'b1;
    stb_n = 0; stb_lat = 0; st_n = 0; ab_n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (reg_wr_strobe) begin
        stb_n++;
        if (stb_lat == 0) stb_lat = k;
      end
      if (start_pulse) st_n++;
      if (abort_pulse) ab_n++;
    end
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_delay"}, 32'(pulse_delay), 32'd6400000);
    chk({tag, "_width"}, 32'(pulse_width), 32'd10);
    chk({tag, "_gap"},   32'(pulse_gap), 32'd13);
    chk({tag, "_cdly"},  32'(capture_delay), 32'd5000);
    chk({tag, "_count"}, 32'(sample_count), 32'd10000);
    chk({tag, "_scr"},   32'(scratch), 32'd0);
    chk({tag, "_flags"}, {28'd0, reject_flag, bad_addr_flag, reg_wr_strobe, start_pulse}, 32'd0);
  endtask

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    #1 chk_defaults("rst");
    chk("rst_addr", 32'(reg_wr_addr), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 2: scratch write, 4-cycle latency, single strobe
    wr(4'd7, 16'h1234, 7, 1'b0);
    chk("scr_val", 32'(scratch), 32'h1234);
    chk("scr_stb_n", 32'(stb_n), 32'd1);
    chk("scr_lat", 32'(stb_lat), 32'd4);
    chk("scr_addr", 32'(reg_wr_addr), 32'd7);

    // 3: 24-bit delay via LO staging then HI commit
    wr(4'd1, 16'hA800, 5, 1'b0);
    chk("lo_nochange", 32'(pulse_delay), 32'd6400000);
    wr(4'd2, 16'hFF62, 5, 1'b0);
    chk("hi_commit", 32'(pulse_delay), 32'h62A800);

    // 4: 2-cycle glitch is filtered
    wr(4'd7, 16'hBEEF, 2, 1'b0);
    chk("glitch_stb", 32'(stb_n), 32'd0);
    chk("glitch_scr", 32'(scratch), 32'h1234);

    // NE rising while WE still low discards the write
    wr(4'd7, 16'h5555, 6, 1'b1);
    chk("ne_abort_stb", 32'(stb_n), 32'd0);
    chk("ne_abort_scr", 32'(scratch), 32'h1234);

    // 5: lock during measurement, sticky reject, clear via CTRL bit7
    mact = 1'b1;
    wr(4'd3, 16'h0005, 5, 1'b0);
    chk("lock_width", 32'(pulse_width), 32'd10);
    chk("lock_reject", 32'(reject_flag), 32'd1);
    chk("lock_stb", 32'(stb_n), 32'd1);
    wr(4'd7, 16'h00AA, 5, 1'b0);
    chk("lock_scr_ok", 32'(scratch), 32'h00AA);
    chk("reject_sticky", 32'(reject_flag), 32'd1);
    wr(4'd0, 16'h0001, 5, 1'b0);
    chk("start_active", 32'(st_n), 32'd1);
    wr(4'd0, 16'h0080, 5, 1'b0);
    chk("clr_reject", 32'(reject_flag), 32'd0);
    mact = 1'b0;

    // bad address: strobe fires, nothing changes, sticky flag
    wr(4'd9, 16'h7777, 5, 1'b0);
    chk("bad_flag", 32'(bad_addr_flag), 32'd1);
    chk("bad_stb", 32'(stb_n), 32'd1);
    chk("bad_waddr", 32'(reg_wr_addr), 32'd9);
    chk("bad_scr", 32'(scratch), 32'h00AA);
    wr(4'd0, 16'h0080, 5, 1'b0);
    chk("clr_bad", 32'(bad_addr_flag), 32'd0);

    // 6: abort beats start; clamps
    wr(4'd0, 16'h0003, 5, 1'b0);
    chk("ab_abort", 32'(ab_n), 32'd1);
    chk("ab_start", 32'(st_n), 32'd0);
    wr(4'd6, 16'd0, 5, 1'b0);
    chk("cnt_zero", 32'(sample_count), 32'd1);
    wr(4'd6, 16'd20000, 5, 1'b0);
    chk("cnt_max", 32'(sample_count), 32'd10000);
    wr(4'd6, 16'd500, 5, 1'b0);
    chk("cnt_mid", 32'(sample_count), 32'd500);
    wr(4'd3, 16'hAB00, 5, 1'b0);
    chk("width_zero", 32'(pulse_width), 32'd1);
    wr(4'd4, 16'h1221, 5, 1'b0);
    chk("gap", 32'(pulse_gap), 32'h21);
    wr(4'd5, 16'hC350, 5, 1'b0);
    chk("cdly", 32'(capture_delay), 32'hC350);

    // reset in the middle of a write: defaults return, write never commits
    @(negedge clk);
    ne = 1'b0; a = 4'd7; d = 16'h9999; we = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    we = 1'b1; ne = 1'b1;
    stb_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (reg_wr_strobe) stb_n++;
    end
    chk("mid_rst_stb", 32'(stb_n), 32'd0);
    chk_defaults("mid_rst");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
